// File: rtl/poly_voice_synth.sv
// poly_voice_synth: polyphonic square-wave tone generator.
// Key press/release events are allocated to VOICES oscillators (lowest free
// voice first, round-robin stealing when all are busy). The active voices are
// summed, saturated to 16-bit signed and registered onto au_left/au_right.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   ev_valid    one-cycle event strobe
//   ev_on       1 = press, 0 = release
//   ev_code     key identifier
//   ev_div      half-period in clk cycles (press only, 0 = rejected)
//   au_left     signed mixed sample
//   au_right    copy of au_left
//   active_mask bit i set while voice i is allocated
//   stolen      one-cycle pulse when a press evicted a voice
module poly_voice_synth #(
  parameter int                 VOICES = 4,
  parameter int                 KEY_W  = 4,
  parameter int                 DIV_W  = 20,
  parameter logic signed [15:0] AMP    = 16'sd4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ev_valid,
  input  logic                    ev_on,
  input  logic [KEY_W-1:0]        ev_code,
  input  logic [DIV_W-1:0]        ev_div,
  output logic signed [15:0]      au_left,
  output logic signed [15:0]      au_right,
  output logic [VOICES-1:0]       active_mask,
  output logic                    stolen
);

  localparam int PTR_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int ACC_W = 16 + $clog2(VOICES) + 1;
  localparam logic signed [ACC_W-1:0] AMP_EXT = ACC_W'(AMP);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  logic [VOICES-1:0] voice_valid;
  logic [KEY_W-1:0]  voice_code [VOICES];
  logic [DIV_W-1:0]  voice_div  [VOICES];
  logic [DIV_W-1:0]  voice_cnt  [VOICES];
  logic [VOICES-1:0] voice_phase;
  logic [PTR_W-1:0]  steal_ptr;

  logic [VOICES-1:0] hit;
  logic              hit_any;
  logic [PTR_W-1:0]  hit_idx;
  logic              free_any;
  logic [PTR_W-1:0]  free_idx;
  logic [PTR_W-1:0]  load_idx;
  logic              press_ev;
  logic              rel_ev;
  logic              do_steal;

  logic signed [ACC_W-1:0] mix_sum_p0;
  logic signed [15:0]      au_p1;

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] x);
    if (x > SAT_MAX)      sat16 = 16'sh7fff;
    else if (x < SAT_MIN) sat16 = 16'sh8000;
    else                  sat16 = x[15:0];
  endfunction

  // Event decode: code match and lowest-index free voice
  always_comb begin
    hit      = '0;
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (voice_valid[i] && voice_code[i] == ev_code) begin
        hit[i]  = 1'b1;
        hit_any = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
    // Scanning downward leaves the lowest free index as the winner.
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (!voice_valid[i]) begin
        free_any = 1'b1;
        free_idx = PTR_W'(i);
      end
    end
  end

  assign press_ev = ev_valid && ev_on && (ev_div != '0);
  assign rel_ev   = ev_valid && !ev_on;
  assign do_steal = press_ev && !hit_any && !free_any;
  assign load_idx = hit_any ? hit_idx : (free_any ? free_idx : steal_ptr);

  // Voice state and oscillators; an event load/clear overrides the oscillator step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        voice_valid[i] <= 1'b0;
        voice_code[i]  <= '0;
        voice_div[i]   <= '0;
        voice_cnt[i]   <= '0;
        voice_phase[i] <= 1'b0;
      end
      steal_ptr <= '0;
      stolen    <= 1'b0;
    end else begin
      stolen <= do_steal;
      if (do_steal)
        steal_ptr <= (steal_ptr == PTR_W'(VOICES - 1)) ? '0 : steal_ptr + PTR_W'(1);
      for (int i = 0; i < VOICES; i++) begin
        if (press_ev && load_idx == PTR_W'(i)) begin
          voice_valid[i] <= 1'b1;
          voice_code[i]  <= ev_code;
          voice_div[i]   <= ev_div;
          voice_cnt[i]   <= '0;
          voice_phase[i] <= 1'b1;
        end else if (rel_ev && hit[i]) begin
          voice_valid[i] <= 1'b0;
          voice_cnt[i]   <= '0;
          voice_phase[i] <= 1'b0;
        end else if (voice_valid[i]) begin
          if (voice_cnt[i] == voice_div[i] - DIV_W'(1)) begin
            voice_cnt[i]   <= '0;
            voice_phase[i] <= ~voice_phase[i];
          end else begin
            voice_cnt[i] <= voice_cnt[i] + DIV_W'(1);
          end
        end else begin
          voice_cnt[i]   <= '0;
          voice_phase[i] <= 1'b0;
        end
      end
    end
  end

  // Stage p0: combinational mix of the current voice set
  always_comb begin
    mix_sum_p0 = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (voice_valid[i])
        mix_sum_p0 = voice_phase[i] ? (mix_sum_p0 + AMP_EXT) : (mix_sum_p0 - AMP_EXT);
    end
  end

  // Stage p1: saturated, registered output sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) au_p1 <= '0;
    else     au_p1 <= sat16(mix_sum_p0);
  end

  assign au_left     = au_p1;
  assign au_right    = au_p1;
  assign active_mask = voice_valid;

endmodule
